// File: rtl/basic_block_window_pkg.sv
// Instruction definitions shared by the basic-block window execution unit:
// instruction width, opcode/data field bounds, opcode enum and an encoder.
package basic_block_window_pkg;

    localparam int INSTRUCTION_WIDTH = 16;
    localparam int OPCODE_MSB        = 15;
    localparam int OPCODE_LSB        = 13;
    localparam int DATA_MSB          = 12;
    localparam int DATA_LSB          = 0;
    localparam int DATA_WIDTH        = DATA_MSB - DATA_LSB + 1;

    typedef enum logic [2:0] {
        ACCEPT                = 3'd0,
        SPLIT                 = 3'd1,
        MATCH                 = 3'd2,
        JMP                   = 3'd3,
        END_WITHOUT_ACCEPTING = 3'd4,
        MATCH_ANY             = 3'd5,
        NOT_MATCH             = 3'd6,
        ACCEPT_PARTIAL        = 3'd7
    } opcode_e;

    // Packs an opcode and its data field into one instruction word.
    function automatic logic [INSTRUCTION_WIDTH-1:0] make_instr(input opcode_e op,
                                                                input logic [DATA_WIDTH-1:0] data);
        return {op, data};
    endfunction

endpackage

// File: rtl/basic_block_window_bb_exec_decode.sv
// Combinational execute stage: from the latched instruction, the thread
// (pc, cc_id) and the character window, produce the successor thread, the
// accept flag and whether a second SPLIT output is still to come.
module bb_exec_decode
    import basic_block_window_pkg::*;
#(
    parameter int PC_WIDTH        = 8,
    parameter int CHARACTER_WIDTH = 8,
    parameter int CC_ID_BITS      = 2
) (
    input  logic [INSTRUCTION_WIDTH-1:0]                   instr_i,
    input  logic                                           exec_2_i,
    input  logic [PC_WIDTH-1:0]                            pc_i,
    input  logic [CC_ID_BITS-1:0]                          cc_id_i,
    input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]     window_i,
    output logic                                           valid_o,
    output logic [PC_WIDTH-1:0]                            pc_o,
    output logic [CC_ID_BITS-1:0]                          cc_id_o,
    output logic                                           to_current_o,
    output logic                                           accept_o,
    output logic                                           to_exec_2_o
);

    opcode_e                    op;
    logic [DATA_WIDTH-1:0]      data;
    logic [CHARACTER_WIDTH-1:0] match_char;
    logic [CHARACTER_WIDTH-1:0] ch;
    logic [PC_WIDTH-1:0]        jump_off;
    logic                       unused_data;

    assign op          = opcode_e'(instr_i[OPCODE_MSB:OPCODE_LSB]);
    assign data        = instr_i[DATA_MSB:DATA_LSB];
    assign match_char  = data[CHARACTER_WIDTH-1:0];
    assign ch          = window_i[cc_id_i*CHARACTER_WIDTH +: CHARACTER_WIDTH];
    assign jump_off    = PC_WIDTH'(data);
    // Upper data bits only matter for some opcodes/widths.
    assign unused_data = ^data;

    // Opcode execution; a consumed character advances cc_id and may wrap
    // into the next window.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned and no latch is inferred.
        valid_o      = 1'b0;
        pc_o         = pc_i + 1'b1;
        cc_id_o      = cc_id_i;
        to_current_o = 1'b1;
        accept_o     = 1'b0;
        to_exec_2_o  = 1'b0;
        case (op)
            MATCH, NOT_MATCH, MATCH_ANY: begin
                if (op == MATCH)          valid_o = (ch == match_char);
                else if (op == NOT_MATCH) valid_o = (ch != match_char) && (ch != '0);
                else                      valid_o = (ch != '0);
                cc_id_o      = cc_id_i + 1'b1;
                to_current_o = (cc_id_i != '1);
            end
            JMP: begin
                valid_o = 1'b1;
                pc_o    = pc_i + jump_off;
            end
            SPLIT: begin
                valid_o = 1'b1;
                if (exec_2_i) begin
                    pc_o = pc_i + jump_off;
                end else begin
                    to_exec_2_o = 1'b1;
                end
            end
            ACCEPT:         accept_o = (ch == '0);
            ACCEPT_PARTIAL: accept_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/basic_block_window.sv
// Regex basic-block execution unit over a window of 2**CC_ID_BITS characters.
// Takes one thread, fetches its instruction, executes it and emits up to two
// successor threads plus an accept pulse.
// Optional one-entry instruction cache: define BB_INSTR_CACHE_EN.
module basic_block_window
    import basic_block_window_pkg::*;
#(
    parameter int PC_WIDTH          = 8,
    parameter int CHARACTER_WIDTH   = 8,
    parameter int CC_ID_BITS        = 2,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0] current_characters,
    input  logic                                       flush,
    input  logic                                       input_pc_valid,
    input  logic [PC_WIDTH-1:0]                        input_pc,
    input  logic [CC_ID_BITS-1:0]                      input_cc_id,
    output logic                                       input_pc_ready,
    output logic                                       memory_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]               memory_addr,
    input  logic                                       memory_ready,
    input  logic [MEMORY_WIDTH-1:0]                    memory_data,
    output logic                                       output_pc_valid,
    output logic [PC_WIDTH-1:0]                        output_pc,
    output logic [CC_ID_BITS-1:0]                      output_cc_id,
    output logic                                       output_pc_is_directed_to_current,
    input  logic                                       output_pc_ready,
    output logic                                       accepts,
    output logic                                       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_SEND,
        S_FETCH_REC,
        S_EXEC_1,
        S_EXEC_2
    } state_e;

    localparam logic [INSTRUCTION_WIDTH-1:0] INSTR_RESET = make_instr(END_WITHOUT_ACCEPTING, '0);

    state_e                         state_q, state_d;
    logic [PC_WIDTH-1:0]            pc_q, pc_d;
    logic [CC_ID_BITS-1:0]          cc_id_q, cc_id_d;
    logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;

    logic                           cache_hit;
    logic [INSTRUCTION_WIDTH-1:0]   cache_instr;

    logic                           dec_valid;
    logic [PC_WIDTH-1:0]            dec_pc;
    logic [CC_ID_BITS-1:0]          dec_cc_id;
    logic                           dec_to_current;
    logic                           dec_accept;
    logic                           dec_to_exec_2;

`ifdef BB_INSTR_CACHE_EN
    logic                           cache_valid_q;
    logic [PC_WIDTH-1:0]            cache_tag_q;
    logic [INSTRUCTION_WIDTH-1:0]   cache_instr_q;

    // A flush in the same cycle as a lookup must force a miss.
    assign cache_hit   = input_pc_valid && cache_valid_q && (cache_tag_q == input_pc) && !flush;
    assign cache_instr = cache_instr_q;

    // One-entry cache filled on every fetch response; flush wins over a fill.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the cache entry is a handful of flops, so it is reset like
        // any other state; only the valid bit actually needs it.
        if (!reset) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_instr_q <= INSTR_RESET;
        end else if (flush) begin
            cache_valid_q <= 1'b0;
        end else if (state_q == S_FETCH_REC) begin
            cache_valid_q <= 1'b1;
            cache_tag_q   <= pc_q;
            cache_instr_q <= memory_data[INSTRUCTION_WIDTH-1:0];
        end
    end
`else
    logic unused_flush;

    assign cache_hit    = 1'b0;
    assign cache_instr  = INSTR_RESET;
    assign unused_flush = flush;
`endif

    bb_exec_decode #(
        .PC_WIDTH        (PC_WIDTH),
        .CHARACTER_WIDTH (CHARACTER_WIDTH),
        .CC_ID_BITS      (CC_ID_BITS)
    ) u_exec_decode (
        .instr_i      (instr_q),
        .exec_2_i     (state_q == S_EXEC_2),
        .pc_i         (pc_q),
        .cc_id_i      (cc_id_q),
        .window_i     (current_characters),
        .valid_o      (dec_valid),
        .pc_o         (dec_pc),
        .cc_id_o      (dec_cc_id),
        .to_current_o (dec_to_current),
        .accept_o     (dec_accept),
        .to_exec_2_o  (dec_to_exec_2)
    );

    assign memory_addr = MEMORY_ADDR_WIDTH'(pc_q);
    assign busy        = (state_q != S_IDLE);

    // State and thread registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cc_id_q <= '0;
            instr_q <= INSTR_RESET;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cc_id_q <= cc_id_d;
            instr_q <= instr_d;
        end
    end

    // Next-state and handshake outputs; execute states only advance when
    // the successor (if any) is taken.
    always_comb begin
        state_d                          = state_q;
        pc_d                             = pc_q;
        cc_id_d                          = cc_id_q;
        instr_d                          = instr_q;
        input_pc_ready                   = 1'b0;
        memory_valid                     = 1'b0;
        output_pc_valid                  = 1'b0;
        output_pc                        = '0;
        output_cc_id                     = '0;
        output_pc_is_directed_to_current = 1'b0;
        accepts                          = 1'b0;
        case (state_q)
            S_IDLE: begin
                input_pc_ready = 1'b1;
                if (input_pc_valid) begin
                    pc_d    = input_pc;
                    cc_id_d = input_cc_id;
                    if (cache_hit) begin
                        instr_d = cache_instr;
                        state_d = S_EXEC_1;
                    end else begin
                        state_d = S_FETCH_SEND;
                    end
                end
            end
            S_FETCH_SEND: begin
                memory_valid = 1'b1;
                if (memory_ready) state_d = S_FETCH_REC;
            end
            S_FETCH_REC: begin
                instr_d = memory_data[INSTRUCTION_WIDTH-1:0];
                state_d = S_EXEC_1;
            end
            S_EXEC_1, S_EXEC_2: begin
                output_pc_valid = dec_valid;
                if (dec_valid) begin
                    output_pc                        = dec_pc;
                    output_cc_id                     = dec_cc_id;
                    output_pc_is_directed_to_current = dec_to_current;
                end
                accepts = dec_accept && (state_q == S_EXEC_1);
                if (!dec_valid || output_pc_ready) begin
                    state_d = dec_to_exec_2 ? S_EXEC_2 : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_basic_block_window.sv
// Directed self-checking bench for basic_block_window (W = 4).
module tb_basic_block_window;
    import basic_block_window_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] chars = '0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_pc = '0;
    logic [1:0]  in_cc = '0;
    logic        in_ready;
    logic        mem_valid;
    logic [10:0] mem_addr;
    logic        mem_ready = 1'b1;
    logic [15:0] mem_data = '0;
    logic        out_valid;
    logic [7:0]  out_pc;
    logic [1:0]  out_cc;
    logic        out_cur;
    logic        out_ready = 1'b1;
    logic        acc;
    logic        busy;

    logic [15:0] mem [0:2047];

    int n_cmp = 0;
    int n_err = 0;
    int acc_total = 0;
    int out_total = 0;
    int mv_total = 0;

`ifdef BB_INSTR_CACHE_EN
    localparam bit CACHED = 1'b1;
`else
    localparam bit CACHED = 1'b0;
`endif

    basic_block_window dut (
        .clk                              (clk),
        .reset                            (reset),
        .current_characters               (chars),
        .flush                            (flush),
        .input_pc_valid                   (in_valid),
        .input_pc                         (in_pc),
        .input_cc_id                      (in_cc),
        .input_pc_ready                   (in_ready),
        .memory_valid                     (mem_valid),
        .memory_addr                      (mem_addr),
        .memory_ready                     (mem_ready),
        .memory_data                      (mem_data),
        .output_pc_valid                  (out_valid),
        .output_pc                        (out_pc),
        .output_cc_id                     (out_cc),
        .output_pc_is_directed_to_current (out_cur),
        .output_pc_ready                  (out_ready),
        .accepts                          (acc),
        .busy                             (busy)
    );

    always #5 clk = ~clk;

    // Instruction memory: data valid the cycle after an accepted request.
    always @(posedge clk) begin
        if (mem_valid && mem_ready) mem_data <= mem[mem_addr];
    end

    // Event counters sampled on the falling edge.
    always @(negedge clk) begin
        if (acc) acc_total <= acc_total + 1;
        if (out_valid && out_ready) out_total <= out_total + 1;
        if (mem_valid) mv_total <= mv_total + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one thread; returns after the handshake edge.
    task automatic send(input logic [7:0] pc, input logic [1:0] cc);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("send_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_pc    = pc;
        in_cc    = cc;
        tick();
        in_valid = 1'b0;
    endtask

    // Latency counts the handshake edge as 1.
    task automatic wait_out(input string tag, input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (lat >= 40) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] pc,
                              input logic [1:0] cc, input logic cur);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_pc"},    32'(out_pc),    32'(pc));
        check({tag, "_cc"},    32'(out_cc),    32'(cc));
        check({tag, "_dir"},   32'(out_cur),   32'(cur));
    endtask

    // Run a thread and count successors and accept pulses it produces.
    task automatic run_count(input string tag, input logic [7:0] pc, input logic [1:0] cc,
                             input int exp_out, input int exp_acc);
        int a0 = acc_total;
        int o0 = out_total;
        send(pc, cc);
        repeat (6) tick();
        check({tag, "_outs"},    32'(out_total - o0), 32'(exp_out));
        check({tag, "_accepts"}, 32'(acc_total - a0), 32'(exp_acc));
    endtask

    initial begin
        int lat;
        int mv0;

        for (int i = 0; i < 2048; i++) mem[i] = make_instr(END_WITHOUT_ACCEPTING, '0);
        mem[5]   = make_instr(MATCH, 13'h61);
        mem[2]   = make_instr(SPLIT, 13'd4);
        mem[0]   = make_instr(ACCEPT, 13'd0);
        mem[250] = make_instr(JMP, 13'd10);
        mem[7]   = make_instr(JMP, 13'd1);
        mem[20]  = make_instr(NOT_MATCH, 13'h61);
        mem[21]  = make_instr(MATCH_ANY, 13'd0);
        mem[30]  = make_instr(ACCEPT_PARTIAL, 13'd0);

        // Reset state.
        repeat (2) tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_accepts",   32'(acc),       32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        reset = 1'b1;
        tick();

        // Window: char3='a', char2=0, char1='x', char0='b'.
        chars = {8'h61, 8'h00, 8'h78, 8'h62};
        send(8'd5, 2'd3);
        wait_out("match_wrap", 1, lat);
        check("match_wrap_latency", 32'(lat), 32'd3);
        expect_out("match_wrap", 8'd6, 2'd0, 1'b0);
        tick();
        check("match_wrap_idle", 32'(busy), 32'd0);
        run_count("match_miss", 8'd5, 2'd0, 0, 0);

        send(8'd20, 2'd0);
        wait_out("not_match", 1, lat);
        expect_out("not_match", 8'd21, 2'd1, 1'b1);
        tick();
        run_count("not_match_nul", 8'd20, 2'd2, 0, 0);
        send(8'd21, 2'd1);
        wait_out("match_any", 1, lat);
        expect_out("match_any", 8'd22, 2'd2, 1'b1);
        tick();
        run_count("match_any_nul", 8'd21, 2'd2, 0, 0);

        // SPLIT with a 3-cycle output stall.
        out_ready = 1'b0;
        send(8'd2, 2'd1);
        wait_out("split1", 1, lat);
        for (int i = 0; i < 3; i++) begin
            expect_out("split1_stall", 8'd3, 2'd1, 1'b1);
            tick();
        end
        expect_out("split1", 8'd3, 2'd1, 1'b1);
        out_ready = 1'b1;
        tick();
        expect_out("split2", 8'd6, 2'd1, 1'b1);
        tick();
        check("split_idle", 32'(busy), 32'd0);
        check("split_done", 32'(out_valid), 32'd0);

        // ACCEPT / ACCEPT_PARTIAL.
        chars = {8'h61, 8'h62, 8'h00, 8'h63};
        run_count("accept_nul", 8'd0, 2'd1, 0, 1);
        chars = {8'h61, 8'h62, 8'h78, 8'h63};
        run_count("accept_x", 8'd0, 2'd1, 0, 0);
        run_count("accept_partial", 8'd30, 2'd1, 0, 1);

        // JMP wrap with a 5-cycle memory stall.
        mem_ready = 1'b0;
        send(8'd250, 2'd2);
        lat = 1;
        for (int i = 0; i < 5; i++) begin
            check("stall_mem_valid", 32'(mem_valid), 32'd1);
            check("stall_mem_addr",  32'(mem_addr),  32'd250);
            tick();
            lat++;
        end
        mem_ready = 1'b1;
        wait_out("jmp_wrap", lat, lat);
        check("jmp_wrap_latency", 32'(lat), 32'd8);
        expect_out("jmp_wrap", 8'd4, 2'd2, 1'b1);
        tick();

        // Instruction cache: pc 7 twice, then flush and refetch.
        mv0 = mv_total;
        send(8'd7, 2'd0);
        wait_out("cache_p1", 1, lat);
        check("cache_p1_latency", 32'(lat), 32'd3);
        expect_out("cache_p1", 8'd8, 2'd0, 1'b1);
        tick();
        check("cache_p1_fetches", 32'(mv_total - mv0), 32'd1);
        mv0 = mv_total;
        send(8'd7, 2'd0);
        wait_out("cache_p2", 1, lat);
        check("cache_p2_latency", 32'(lat), CACHED ? 32'd1 : 32'd3);
        expect_out("cache_p2", 8'd8, 2'd0, 1'b1);
        tick();
        check("cache_p2_fetches", 32'(mv_total - mv0), CACHED ? 32'd0 : 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mv0 = mv_total;
        send(8'd7, 2'd0);
        wait_out("cache_p3", 1, lat);
        check("cache_p3_latency", 32'(lat), 32'd3);
        tick();
        check("cache_p3_fetches", 32'(mv_total - mv0), 32'd1);

        // Reset while stalled in the second SPLIT output.
        out_ready = 1'b0;
        send(8'd2, 2'd0);
        wait_out("rst_split", 1, lat);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        expect_out("rst_split2", 8'd6, 2'd0, 1'b1);
        tick();
        check("rst_split2_held", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_async_out_valid", 32'(out_valid), 32'd0);
        check("rst_async_busy",      32'(busy),      32'd0);
        check("rst_async_out_pc",    32'(out_pc),    32'd0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        check("rst_release_in_ready",  32'(in_ready),  32'd1);
        check("rst_release_out_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
